// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the MEM stage and the DMA engine.
package dmem_arb_pkg;

  typedef enum logic {IDLE, DMA_BURST} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  localparam int BURST_LEN_W = 4;
  localparam int WORD_IDX_W  = 8;

  // Advance to the next word inside the current 1 KiB window; the high and byte bits stay put.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    logic [31:0] nxt;
    nxt = addr;
    nxt[2 +: WORD_IDX_W] = addr[2 +: WORD_IDX_W] + WORD_IDX_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/dma_burst_ctr.sv
// Burst address/beat tracker: latches the DMA start address and length, then steps one word per beat.
module dma_burst_ctr
  import dmem_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [31:0]            load_addr,
  input  logic [BURST_LEN_W-1:0] load_len,
  input  logic                   advance,
  output logic [31:0]            addr,
  output logic                   last
);

  logic [31:0]            addr_q;
  logic [BURST_LEN_W-1:0] remaining_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else if (load) begin
      addr_q      <= load_addr;
      remaining_q <= load_len;
    end else if (advance) begin
      addr_q      <= next_word_addr(addr_q);
      remaining_q <= remaining_q - BURST_LEN_W'(1);
    end
  end

  assign addr = addr_q;
  assign last = (remaining_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU single beats normally win, DMA bursts are non-interruptible,
// and a CPU run limit guarantees the DMA eventually gets the port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_CPU_RUN = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic                   cpu_stall,
  output logic                   cpu_rvalid,
  output logic [31:0]            cpu_rdata,
  input  logic                   dma_req,
  input  logic                   dma_we,
  input  logic [31:0]            dma_addr,
  input  logic [BURST_LEN_W-1:0] dma_len,
  input  logic [31:0]            dma_wdata,
  output logic                   dma_wready,
  output logic                   dma_busy,
  output logic                   dma_rvalid,
  output logic [31:0]            dma_rdata,
  output logic                   dma_done,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic                   mem_read,
  output logic                   mem_write,
  input  logic [31:0]            mem_rdata
);

  localparam int RUN_W = $clog2(MAX_CPU_RUN + 1);

  arb_state_t       state, state_next;
  logic [RUN_W-1:0] run_cnt;
  logic             burst_we;
  logic             cpu_grant, dma_grant, beat;
  logic [31:0]      burst_addr;
  logic             burst_last;
  logic             rd_pend_q, dma_done_q;
  owner_t           rd_owner_q;

  dma_burst_ctr u_burst_ctr (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (dma_grant),
    .load_addr (dma_addr),
    .load_len  (dma_len),
    .advance   (beat),
    .addr      (burst_addr),
    .last      (burst_last)
  );

  // Whole command path sits under reset_n so the memory never sees a CPU access during reset.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    cpu_grant  = 1'b0;
    dma_grant  = 1'b0;
    beat       = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    dma_wready = 1'b0;
    if (reset_n) begin
      unique case (state)
        IDLE: begin
          if (cpu_req && (!dma_req || run_cnt < RUN_W'(MAX_CPU_RUN))) begin
            cpu_grant = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = !cpu_we;
            mem_write = cpu_we;
          end else if (dma_req) begin
            dma_grant  = 1'b1;
            state_next = DMA_BURST;
          end
        end
        DMA_BURST: begin
          beat     = 1'b1;
          mem_addr = burst_addr;
          if (burst_we) begin
            mem_write  = 1'b1;
            mem_wdata  = dma_wdata;
            dma_wready = 1'b1;
          end else begin
            mem_read = 1'b1;
          end
          if (burst_last) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      run_cnt    <= '0;
      burst_we   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_CPU;
      dma_done_q <= 1'b0;
    end else begin
      state      <= state_next;
      rd_pend_q  <= mem_read;
      rd_owner_q <= (state == DMA_BURST) ? OWN_DMA : OWN_CPU;
      dma_done_q <= beat && burst_last;
      if (dma_grant) burst_we <= dma_we;
      if (!dma_req || dma_grant) begin
        run_cnt <= '0;
      end else if (cpu_grant && run_cnt < RUN_W'(MAX_CPU_RUN)) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

  assign cpu_stall  = reset_n && cpu_req && !cpu_grant;
  assign dma_busy   = dma_grant || (state == DMA_BURST);
  assign dma_done   = dma_done_q;
  assign cpu_rvalid = rd_pend_q && (rd_owner_q == OWN_CPU);
  assign dma_rvalid = rd_pend_q && (rd_owner_q == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule
